// File: rtl/fpu_uni2sp_pack_if.sv
// fpu_uni2sp_pack_if: operand/result handshake bundle for the unified-to-single packer
interface fpu_uni2sp_pack_if;
  logic        din_uni_y_sgn;
  logic [5:0]  din_uni_y_exp;
  logic [21:0] din_uni_y_man_dn;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout_sp;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  modport master (
    output din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn, din_valid, dout_ready,
    input  din_ready, dout_sp, dout_valid, busy
  );
  modport slave (
    input  din_uni_y_sgn, din_uni_y_exp, din_uni_y_man_dn, din_valid, dout_ready,
    output din_ready, dout_sp, dout_valid, busy
  );
endinterface

// File: rtl/fpu_uni2sp_pack.sv
// fpu_uni2sp_pack: normalises a unified-format FPALU result over several cycles and packs it as IEEE single
module fpu_uni2sp_pack #(
  parameter int UNI_BIAS   = 31,
  parameter int SP_BIAS    = 127,
  parameter int SHIFT_STEP = 4
) (
  input logic                clk,
  input logic                rst_n,
  fpu_uni2sp_pack_if.slave   bus
);
  localparam logic [8:0] BIAS_D = 9'(SP_BIAS - UNI_BIAS);
  localparam logic [8:0] STEP9  = 9'(SHIFT_STEP);
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  state_t      state;
  logic        s;
  logic [8:0]  e;
  logic [21:0] m;
  logic [31:0] sp_q;
  logic        v_q;
  logic        top_zero;
  assign top_zero       = (m >> (22 - SHIFT_STEP)) == '0;
  assign bus.din_ready  = state == IDLE;
  assign bus.busy       = state != IDLE;
  assign bus.dout_sp    = sp_q;
  assign bus.dout_valid = v_q;
  // capture operand, shift the lead bit up to m[21] in coarse then fine steps, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= 1'b0;
      e     <= '0;
      m     <= '0;
      sp_q  <= '0;
      v_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.din_valid) begin
          s     <= bus.din_uni_y_sgn;
          m     <= bus.din_uni_y_man_dn;
          e     <= {3'b000, bus.din_uni_y_exp} + BIAS_D;
          state <= NORM;
        end
        NORM: if (m == '0) begin
          sp_q  <= {s, 31'b0};
          v_q   <= 1'b1;
          state <= DONE;
        end else if (m[21]) begin
          sp_q  <= {s, e[7:0], m[20:0], 2'b00};
          v_q   <= 1'b1;
          state <= DONE;
        end else if (top_zero && e > STEP9) begin
          m <= m << SHIFT_STEP;
          e <= e - STEP9;
        end else if (e > 9'd1) begin
          m <= m << 1;
          e <= e - 9'd1;
        end else begin
          sp_q  <= {s, 31'b0};
          v_q   <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.dout_ready) begin
          v_q   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_uni2sp_pack.sv
// tb_fpu_uni2sp_pack: directed vector table, handshake corner cases and a random stream against a real-arithmetic model
module tb_fpu_uni2sp_pack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  fpu_uni2sp_pack_if b ();
  fpu_uni2sp_pack dut (.clk(clk), .rst_n(rst_n), .bus(b));
  // free-running clock
  always #5 clk = ~clk;
  typedef struct {
    logic        sgn;
    logic [5:0]  exp;
    logic [21:0] man;
    logic [31:0] sp;
    int          lat;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [31:0] ref_sp(input logic sg, input logic [5:0] ex, input logic [21:0] mn);
    real         v;
    logic [63:0] d;
    if (mn == '0) return {sg, 31'b0};
    v = real'(mn) * (2.0 ** (real'(ex) - 52.0));
    d = $realtobits(v);
    return {sg, 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  task automatic start(input logic sg, input logic [5:0] ex, input logic [21:0] mn, output int lat);
    int w = 0;
    b.din_uni_y_sgn    = sg;
    b.din_uni_y_exp    = ex;
    b.din_uni_y_man_dn = mn;
    b.din_valid        = 1'b1;
    while (!b.din_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 b.din_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!b.dout_valid && lat < 64);
  endtask
  task automatic finish_out();
    b.dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.dout_ready = 1'b0;
  endtask
  initial begin
    int          lat;
    logic [31:0] held;
    logic [31:0] q[$];
    logic [31:0] exp_sp;
    logic [31:0] act_sp;
    logic        acc;
    logic        dlv;
    int          sent;
    int          got;
    int          cyc;
    vt[0]  = '{1'b0, 6'd31, 22'h200000, 32'h3F800000, 1};
    vt[1]  = '{1'b0, 6'd40, 22'h000001, 32'h39800000, 7};
    vt[2]  = '{1'b1, 6'd17, 22'h000000, 32'h80000000, 1};
    vt[3]  = '{1'b0, 6'd0,  22'h100000, 32'h2F800000, 2};
    vt[4]  = '{1'b1, 6'd31, 22'h300000, 32'hBFC00000, 1};
    vt[5]  = '{1'b0, 6'd32, 22'h200000, 32'h40000000, 1};
    vt[6]  = '{1'b0, 6'd63, 22'h3FFFFF, 32'h4FFFFFFC, 1};
    vt[7]  = '{1'b0, 6'd31, 22'h080000, 32'h3E800000, 3};
    vt[8]  = '{1'b1, 6'd31, 22'h020000, 32'hBD800000, 2};
    vt[9]  = '{1'b0, 6'd31, 22'h000003, 32'h35C00000, 6};
    vt[10] = '{1'b0, 6'd0,  22'h000001, 32'h25800000, 7};
    b.din_uni_y_sgn    = 1'b0;
    b.din_uni_y_exp    = '0;
    b.din_uni_y_man_dn = '0;
    b.din_valid        = 1'b0;
    b.dout_ready       = 1'b0;
    #12;
    chk("rst_din_ready", 32'(b.din_ready), 32'd1);
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_dout_valid", 32'(b.dout_valid), 32'd0);
    chk("rst_dout_sp", b.dout_sp, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      start(vt[i].sgn, vt[i].exp, vt[i].man, lat);
      chk($sformatf("vec%0d_sp", i), b.dout_sp, vt[i].sp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      finish_out();
      chk($sformatf("vec%0d_idle", i), {30'b0, b.dout_valid, b.din_ready}, 32'd1);
    end
    start(1'b0, 6'd0, 22'h100000, lat);
    held = b.dout_sp;
    b.din_uni_y_sgn    = 1'b1;
    b.din_uni_y_exp    = 6'd5;
    b.din_uni_y_man_dn = 22'h3FFFFF;
    b.din_valid        = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("hold%0d_sp", i), b.dout_sp, 32'h2F800000);
      chk($sformatf("hold%0d_flags", i), {29'b0, b.dout_valid, b.din_ready, b.busy}, 32'b101);
    end
    b.din_valid  = 1'b0;
    b.dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b.dout_ready = 1'b0;
    chk("hold_release_flags", {29'b0, b.dout_valid, b.din_ready, b.busy}, 32'b010);
    chk("hold_release_sp", b.dout_sp, held);
    b.din_uni_y_sgn    = 1'b0;
    b.din_uni_y_exp    = 6'd40;
    b.din_uni_y_man_dn = 22'h000001;
    b.din_valid        = 1'b1;
    @(posedge clk);
    #1 b.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_norm_busy", 32'(b.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_flags", {29'b0, b.dout_valid, b.din_ready, b.busy}, 32'b010);
    chk("arst_sp", b.dout_sp, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_out", 32'(b.dout_valid), 32'd0);
    start(1'b0, 6'd31, 22'h200000, lat);
    chk("post_rst_sp", b.dout_sp, 32'h3F800000);
    chk("post_rst_lat", 32'(lat), 32'd1);
    finish_out();
    sent = 0;
    got  = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (got < 1000 && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      if (acc) b.din_valid = 1'b0;
      if (!b.din_valid && sent < 1000) begin
        b.din_uni_y_sgn    = 1'($urandom);
        b.din_uni_y_exp    = 6'($urandom);
        b.din_uni_y_man_dn = 22'($urandom) >> $urandom_range(0, 22);
        b.din_valid        = 1'b1;
      end
      b.dout_ready = $urandom_range(0, 2) != 0;
      #1;
      acc    = b.din_valid && b.din_ready;
      dlv    = b.dout_valid && b.dout_ready;
      act_sp = b.dout_sp;
      if (acc) begin
        q.push_back(ref_sp(b.din_uni_y_sgn, b.din_uni_y_exp, b.din_uni_y_man_dn));
        sent++;
      end
      @(posedge clk);
      if (dlv) begin
        got++;
        if (q.size() == 0) begin
          chk("rand_spurious_out", 32'(q.size()), 32'd1);
        end else begin
          exp_sp = q.pop_front();
          chk($sformatf("rand%0d_sp", got), act_sp, exp_sp);
        end
      end
    end
    @(negedge clk);
    b.din_valid  = 1'b0;
    b.dout_ready = 1'b0;
    chk("rand_out_count", 32'(got), 32'd1000);
    chk("rand_in_count", 32'(sent), 32'd1000);
    chk("rand_leftover", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
